// File: rtl/param_pipelined_alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//
// Purpose:
//   Shared definitions for the parametrised pipelined ALU: opcode encodings,
//   flag bit positions inside the 5-bit flags word, and a helper that sizes
//   the shift-amount field from the datapath width.
//
// Contents:
//   OP_ADD .. OP_SLTU  legal 4-bit opcodes (12..15 are illegal)
//   FLG_Z .. FLG_ERR   bit indices into flags = {err, V, C, N, Z}
//   shamtWidth()       number of b bits used as a shift amount
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOTA = 4'd5;
    localparam logic [3:0] OP_PASSB = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;

    // Opcodes from this value upward are illegal.
    localparam logic [3:0] OP_FIRST_ILLEGAL = 4'd12;

    localparam int FLG_Z   = 0;
    localparam int FLG_N   = 1;
    localparam int FLG_C   = 2;
    localparam int FLG_V   = 3;
    localparam int FLG_ERR = 4;
    localparam int NUM_FLAGS = 5;

    // A WIDTH-bit operand can only be shifted by 0..WIDTH-1, so only the low
    // clog2(WIDTH) bits of b carry a meaningful shift amount.
    function automatic int shamtWidth(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/param_pipelined_alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//
// Purpose:
//   Purely combinational ALU slice used by the second pipeline stage.
//   Computes the result and the {err, V, C, N, Z} status flags for one
//   operation.
//
// Parameters:
//   WIDTH   datapath width (power of two, >= 8)
//
// Ports:
//   a       in   WIDTH  operand A
//   b       in   WIDTH  operand B (low clog2(WIDTH) bits are the shift amount)
//   alu_op  in   4      opcode, see alu_pkg
//   result  out  WIDTH  operation result (0 for illegal opcodes)
//   flags   out  5      {err, V, C, N, Z}
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           alu_op,
    output logic [WIDTH-1:0]     result,
    output logic [NUM_FLAGS-1:0] flags
);

    localparam int SHW = shamtWidth(WIDTH);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic             w_carry;
    logic             w_ovf;
    logic             w_err;

    // Both adders are one bit wider than the datapath so the top bit is the
    // carry-out. Subtraction is done as A + ~B + 1, which makes the carry-out
    // an inverted borrow: C=1 means A >= B unsigned.
    assign w_sum   = {1'b0, a} + {1'b0, b};
    assign w_diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_shamt = b[SHW-1:0];

    // Opcode decode. Carry and overflow only have meaning for ADD/SUB and
    // stay 0 elsewhere; anything outside the legal range raises err and
    // leaves the result at 0.
    always_comb begin
        result  = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (alu_op)
            OP_ADD: begin
                result  = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result  = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NOTA:  result = ~a;
            OP_PASSB: result = b;
            OP_SHL:   result = a << w_shamt;
            OP_SHR:   result = a >> w_shamt;
            OP_SRA:   result = $signed(a) >>> w_shamt;
            OP_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  result = {{(WIDTH-1){1'b0}}, (a < b)};
            default:  w_err  = 1'b1;
        endcase
    end

    // Flag packing. An illegal opcode reports only err, so Z and N are
    // suppressed even though the forced-zero result would otherwise set Z.
    always_comb begin
        flags          = '0;
        flags[FLG_Z]   = !w_err && (result == '0);
        flags[FLG_N]   = !w_err && result[WIDTH-1];
        flags[FLG_C]   = w_carry;
        flags[FLG_V]   = w_ovf;
        flags[FLG_ERR] = w_err;
    end

endmodule

// File: rtl/param_pipelined_alu.sv
// ---------------------------------------------------------------------------
// param_pipelined_alu
//
// Purpose:
//   Pipelined ALU with configurable width and depth, valid/ready handshakes
//   on both ends and a sideband tag carried alongside each operation.
//   Stage 1 captures the operands, stage 2 captures the alu_core result and
//   flags, and stages 3..STAGES are plain delay stages. The outputs come
//   straight from the last stage's registers.
//
// Parameters:
//   WIDTH   datapath width (power of two, >= 8)
//   STAGES  register stages from input to output (>= 2)
//   TAG_W   width of the sideband tag
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      operation presented on a/b/alu_op/in_tag
//   in_ready   out  1      an operation can be accepted this cycle
//   a, b       in   WIDTH  operands
//   alu_op     in   4      opcode
//   in_tag     in   TAG_W  tag, returned unchanged on out_tag
//   out_valid  out  1      result/flags/out_tag hold a valid operation
//   out_ready  in   1      consumer takes the result this cycle
//   result     out  WIDTH  operation result
//   flags      out  5      {err, V, C, N, Z}
//   out_tag    out  TAG_W  tag of the operation on the outputs
// ---------------------------------------------------------------------------
module param_pipelined_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           alu_op,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [NUM_FLAGS-1:0] flags,
    output logic [TAG_W-1:0]     out_tag
);

    // Stage 1: captured operands, opcode and tag.
    logic                 r_s1Valid;
    logic [WIDTH-1:0]     r_s1A;
    logic [WIDTH-1:0]     r_s1B;
    logic [3:0]           r_s1Op;
    logic [TAG_W-1:0]     r_s1Tag;

    // Stages 2..STAGES: computed result, flags and tag.
    logic [STAGES:2]      r_stgValid;
    logic [WIDTH-1:0]     r_stgResult [2:STAGES];
    logic [NUM_FLAGS-1:0] r_stgFlags  [2:STAGES];
    logic [TAG_W-1:0]     r_stgTag    [2:STAGES];

    // w_ready[i] is the ready of stage i; index STAGES+1 is the consumer.
    logic [STAGES+1:1]    w_ready;

    logic [WIDTH-1:0]     w_coreResult;
    logic [NUM_FLAGS-1:0] w_coreFlags;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (r_s1A),
        .b      (r_s1B),
        .alu_op (r_s1Op),
        .result (w_coreResult),
        .flags  (w_coreFlags)
    );

    // Bubble-collapsing ready chain, evaluated from the output backwards.
    // A stage may take new data when it is empty or when the stage after it
    // is about to take its current contents, so empty slots ahead of a
    // stall keep filling. Keeping the whole chain in one block lets each
    // entry depend on the next without a combinational self-loop.
    always_comb begin
        w_ready = '0;
        w_ready[STAGES+1] = out_ready;
        for (int i = STAGES; i >= 2; i--) begin
            w_ready[i] = !r_stgValid[i] || w_ready[i+1];
        end
        w_ready[1] = !r_s1Valid || w_ready[2];
    end

    // Stage 1 valid bit: follows in_valid whenever the stage can advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1Valid <= 1'b0;
        end else if (w_ready[1]) begin
            r_s1Valid <= in_valid;
        end
    end

    // Stage 1 payload: only loaded on a real input transfer so that an empty
    // stage keeps its old contents. It needs no reset because the valid bit
    // alone decides whether it means anything.
    always_ff @(posedge clk) begin
        if (in_valid && w_ready[1]) begin
            r_s1A   <= a;
            r_s1B   <= b;
            r_s1Op  <= alu_op;
            r_s1Tag <= in_tag;
        end
    end

    // Valid bits of stages 2..STAGES. Each stage copies its predecessor's
    // valid bit when it can advance and holds otherwise, which gives the
    // in-order, no-loss, no-duplicate behaviour under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stgValid <= '0;
        end else begin
            if (w_ready[2]) begin
                r_stgValid[2] <= r_s1Valid;
            end
            for (int i = 3; i <= STAGES; i++) begin
                if (w_ready[i]) begin
                    r_stgValid[i] <= r_stgValid[i-1];
                end
            end
        end
    end

    // Payload of stages 2..STAGES. Stage 2 captures the ALU output, later
    // stages shift it along. Only the last stage drives the ports, so it is
    // the only payload cleared by reset; the rest hold stale data harmlessly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stgResult[STAGES] <= '0;
            r_stgFlags[STAGES]  <= '0;
            r_stgTag[STAGES]    <= '0;
        end else begin
            if (r_s1Valid && w_ready[2]) begin
                r_stgResult[2] <= w_coreResult;
                r_stgFlags[2]  <= w_coreFlags;
                r_stgTag[2]    <= r_s1Tag;
            end
            for (int i = 3; i <= STAGES; i++) begin
                if (r_stgValid[i-1] && w_ready[i]) begin
                    r_stgResult[i] <= r_stgResult[i-1];
                    r_stgFlags[i]  <= r_stgFlags[i-1];
                    r_stgTag[i]    <= r_stgTag[i-1];
                end
            end
        end
    end

    assign in_ready  = w_ready[1];
    assign out_valid = r_stgValid[STAGES];
    assign result    = r_stgResult[STAGES];
    assign flags     = r_stgFlags[STAGES];
    assign out_tag   = r_stgTag[STAGES];

endmodule
